itable_fetch_sequencer: RTL and testbench

- Upstream stage of the DECODER_I_* family.
- Fetches the opcode byte over a req/ready memory handshake and holds it as registered ITABLE/notITABLE. Drives the decoder enable.
- Sequences the M1 (opcode) and operand-head cycles from decoder feedback (P2_Set_CM1, P2_Reset_ITABLE, Pa_Ophd).
- Presents the fetched operand byte n to the register-file write path in a dedicated writeback cycle.

---
 rtl/itable_fetch_sequencer_pkg.sv | 20 ++
 rtl/itable_fetch_sequencer_timer.sv | 30 +++
 rtl/itable_fetch_sequencer.sv | 136 +++++++++++++
 tb/tb_itable_fetch_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/itable_fetch_sequencer_pkg.sv
// Shared types and constants for the opcode fetch sequencer.
// The state encoding is fixed so that the decoder family can trace it.
package itable_fetch_sequencer_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] RESET_OPCODE_DEFAULT = 8'h00;

  typedef enum logic [2:0] {
    ST_M1_REQ    = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXEC      = 3'd2,
    ST_OP_REQ    = 3'd3,
    ST_WRITEBACK = 3'd4
  } state_e;

  function automatic logic is_req_state(input state_e s);
    return (s == ST_M1_REQ) || (s == ST_OP_REQ);
  endfunction

endpackage

// File: rtl/itable_fetch_sequencer_timer.sv
// Bus wait-cycle counter with terminal compare, shared by both request states.
// LIMIT of 0 never expires; the count saturates so it cannot wrap into a false expiry.
module itable_fetch_sequencer_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != CNT_MAX)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  always_comb begin
    expired = (LIMIT != 0) && (count_reg == CW'(LIMIT));
  end

endmodule

// File: rtl/itable_fetch_sequencer.sv
// Opcode/operand fetch sequencer feeding the decoder: latches ITABLE and its
// registered complement, sequences M1/operand-head cycles from decoder feedback.
module itable_fetch_sequencer
  import itable_fetch_sequencer_pkg::*;
#(
  parameter int                BUS_TIMEOUT  = 15,
  parameter logic [BYTE_W-1:0] RESET_OPCODE = RESET_OPCODE_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [BYTE_W-1:0] Bus_Data,
  input  logic              Bus_Ready,
  output logic              Bus_Req,
  output logic              PC_Inc,
  output logic [BYTE_W-1:0] ITABLE,
  output logic [BYTE_W-1:0] notITABLE,
  output logic              Dec_Enable,
  output logic              CM1,
  output logic [BYTE_W-1:0] Operand,
  output logic              Operand_Valid,
  output logic              Bus_Err,
  input  logic              P2_Set_CM1,
  input  logic              P2_Reset_ITABLE,
  input  logic              Pa_Ophd
);

  state_e            state_reg, state_next;
  logic [BYTE_W-1:0] itable_reg, itable_next;
  logic [BYTE_W-1:0] notitable_reg;
  logic [BYTE_W-1:0] operand_reg, operand_next;

  logic in_req, expired, req_active, accept, abort;
  logic timer_clear, timer_inc, dec_en;

  // RESET gates the strobes so a Bus_Ready in the reset cycle is never accepted.
  always_comb begin
    in_req      = is_req_state(state_reg);
    req_active  = in_req && !expired && !RESET;
    accept      = req_active && Bus_Ready;
    abort       = in_req && expired && !RESET;
    timer_clear = !in_req || accept || expired;
    timer_inc   = in_req && !Bus_Ready;
    dec_en      = (state_reg == ST_DECODE) || (state_reg == ST_EXEC) ||
                  (state_reg == ST_WRITEBACK);
  end

  itable_fetch_sequencer_timer #(
    .LIMIT (BUS_TIMEOUT)
  ) u_fetch_wait_timer (
    .clk     (CLK),
    .srst    (RESET),
    .clear   (timer_clear),
    .inc     (timer_inc),
    .expired (expired)
  );

  always_comb begin
    state_next   = state_reg;
    itable_next  = itable_reg;
    operand_next = operand_reg;

    if (dec_en && P2_Reset_ITABLE) begin
      itable_next = RESET_OPCODE;
    end

    case (state_reg)
      ST_M1_REQ: begin
        if (abort) begin
          itable_next = RESET_OPCODE;
          state_next  = ST_M1_REQ;
        end else if (accept) begin
          itable_next = Bus_Data;
          state_next  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Operand head wins; the decoder repeats P2_Set_CM1 in WRITEBACK.
        if (Pa_Ophd) begin
          state_next = ST_OP_REQ;
        end else if (P2_Set_CM1) begin
          state_next = ST_M1_REQ;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (P2_Set_CM1) begin
          state_next = ST_M1_REQ;
        end
      end
      ST_OP_REQ: begin
        if (abort) begin
          itable_next = RESET_OPCODE;
          state_next  = ST_M1_REQ;
        end else if (accept) begin
          operand_next = Bus_Data;
          state_next   = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: begin
        state_next = P2_Set_CM1 ? ST_M1_REQ : ST_EXEC;
      end
      default: begin
        state_next = ST_M1_REQ;
      end
    endcase
  end

  // ITABLE and its complement share one edge so they can never disagree.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg     <= ST_M1_REQ;
      itable_reg    <= RESET_OPCODE;
      notitable_reg <= ~RESET_OPCODE;
      operand_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      itable_reg    <= itable_next;
      notitable_reg <= ~itable_next;
      operand_reg   <= operand_next;
    end
  end

  always_comb begin
    Bus_Req       = req_active;
    PC_Inc        = accept;
    Bus_Err       = abort;
    CM1           = (state_reg == ST_M1_REQ);
    Dec_Enable    = dec_en;
    Operand_Valid = (state_reg == ST_WRITEBACK) && !RESET;
    ITABLE        = itable_reg;
    notITABLE     = notitable_reg;
    Operand       = operand_reg;
  end

endmodule

// File: tb/tb_itable_fetch_sequencer.sv
// Directed bench for the fetch sequencer: each task walks one scenario cycle
// by cycle and compares the outputs with hand-derived values.
module tb_itable_fetch_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] bus_data;
  logic       bus_ready;
  logic       bus_req;
  logic       pc_inc;
  logic [7:0] itable;
  logic [7:0] not_itable;
  logic       dec_enable;
  logic       cm1;
  logic [7:0] operand;
  logic       operand_valid;
  logic       bus_err;
  logic       p2_set_cm1;
  logic       p2_reset_itable;
  logic       pa_ophd;

  int errors = 0;
  int checks = 0;

  itable_fetch_sequencer #(
    .BUS_TIMEOUT  (4),
    .RESET_OPCODE (8'h00)
  ) dut (
    .CLK             (clk),
    .RESET           (reset),
    .Bus_Data        (bus_data),
    .Bus_Ready       (bus_ready),
    .Bus_Req         (bus_req),
    .PC_Inc          (pc_inc),
    .ITABLE          (itable),
    .notITABLE       (not_itable),
    .Dec_Enable      (dec_enable),
    .CM1             (cm1),
    .Operand         (operand),
    .Operand_Valid   (operand_valid),
    .Bus_Err         (bus_err),
    .P2_Set_CM1      (p2_set_cm1),
    .P2_Reset_ITABLE (p2_reset_itable),
    .Pa_Ophd         (pa_ophd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus_data = 8'h00; bus_ready = 1'b0;
    p2_set_cm1 = 1'b0; p2_reset_itable = 1'b0; pa_ophd = 1'b0;
    step();
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    #1;
    checks++; if (cm1 !== 1'b1) begin errors++; $display("FAIL reset_cm1: got %b want 1", cm1); end
    checks++; if (itable !== 8'h00) begin errors++; $display("FAIL reset_itable: got %h want 00", itable); end
    checks++; if (not_itable !== 8'hFF) begin errors++; $display("FAIL reset_notitable: got %h want ff", not_itable); end
    checks++; if (operand !== 8'h00) begin errors++; $display("FAIL reset_operand: got %h want 00", operand); end
    checks++; if ({pc_inc, bus_err, operand_valid, dec_enable, bus_req} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b want 00000", {pc_inc, bus_err, operand_valid, dec_enable, bus_req});
    end
    reset = 1'b0;
    #1;
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL reset_release_req: got %b want 1", bus_req); end
    $display("reset done");
  endtask

  // Zero-wait LD r,n with Pa_Ophd and P2_Set_CM1 coincident in DECODE.
  task automatic test_ld_r_n();
    int pcs = 0;
    bus_ready = 1'b1; bus_data = 8'h3E; #1;
    checks++; if (cm1 !== 1'b1) begin errors++; $display("FAIL ld_c1_cm1: got %b want 1", cm1); end
    pcs += int'(pc_inc);
    step();
    bus_ready = 1'b0; pa_ophd = 1'b1; p2_set_cm1 = 1'b1; #1;
    checks++; if (dec_enable !== 1'b1 || cm1 !== 1'b0) begin
      errors++; $display("FAIL ld_c2_decode: got en=%b cm1=%b want en=1 cm1=0", dec_enable, cm1);
    end
    checks++; if (itable !== 8'h3E) begin errors++; $display("FAIL ld_c2_itable: got %h want 3e", itable); end
    pcs += int'(pc_inc);
    step();
    pa_ophd = 1'b0; p2_set_cm1 = 1'b0; bus_ready = 1'b1; bus_data = 8'h5A; #1;
    checks++; if (bus_req !== 1'b1 || dec_enable !== 1'b0) begin
      errors++; $display("FAIL ld_c3_opreq: got req=%b en=%b want req=1 en=0", bus_req, dec_enable);
    end
    pcs += int'(pc_inc);
    step();
    bus_ready = 1'b0; p2_set_cm1 = 1'b1; #1;
    checks++; if (operand_valid !== 1'b1 || operand !== 8'h5A) begin
      errors++; $display("FAIL ld_c4_writeback: got valid=%b operand=%h want valid=1 operand=5a", operand_valid, operand);
    end
    pcs += int'(pc_inc);
    step();
    p2_set_cm1 = 1'b0; #1;
    checks++; if (cm1 !== 1'b1 || operand_valid !== 1'b0) begin
      errors++; $display("FAIL ld_c5_m1: got cm1=%b valid=%b want cm1=1 valid=0", cm1, operand_valid);
    end
    checks++; if (pcs !== 2) begin errors++; $display("FAIL ld_pc_inc_count: got %0d want 2", pcs); end
    $display("ld r,n opcode=3e operand=%h pc_inc=%0d", operand, pcs);
  endtask

  task automatic test_single_cycle();
    bus_ready = 1'b1; bus_data = 8'h00; #1;
    checks++; if (pc_inc !== 1'b1) begin errors++; $display("FAIL single_pc_inc: got %b want 1", pc_inc); end
    step();
    bus_ready = 1'b0; p2_set_cm1 = 1'b1; #1;
    checks++; if (itable !== 8'h00 || not_itable !== 8'hFF || dec_enable !== 1'b1) begin
      errors++; $display("FAIL single_decode: got itable=%h not=%h en=%b want 00 ff 1", itable, not_itable, dec_enable);
    end
    step();
    p2_set_cm1 = 1'b0; #1;
    checks++; if (cm1 !== 1'b1 || not_itable !== 8'hFF) begin
      errors++; $display("FAIL single_back_to_m1: got cm1=%b not=%h want 1 ff", cm1, not_itable);
    end
    $display("single-cycle op opcode=%h", itable);
  endtask

  task automatic test_wait_states();
    int reqs = 0;
    int pcs = 0;
    bus_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; reqs += int'(bus_req); pcs += int'(pc_inc);
      step();
    end
    bus_ready = 1'b1; bus_data = 8'hA5; #1;
    reqs += int'(bus_req); pcs += int'(pc_inc);
    step();
    bus_ready = 1'b0; #1;
    checks++; if (reqs !== 4) begin errors++; $display("FAIL wait_req_cycles: got %0d want 4", reqs); end
    checks++; if (pcs !== 1) begin errors++; $display("FAIL wait_pc_inc: got %0d want 1", pcs); end
    checks++; if (itable !== 8'hA5 || not_itable !== 8'h5A) begin
      errors++; $display("FAIL wait_itable: got %h/%h want a5/5a", itable, not_itable);
    end
    $display("wait-state fetch opcode=%h req_cycles=%0d", itable, reqs);
    pa_ophd = 1'b1;
    step();
    pa_ophd = 1'b0;
  endtask

  // Entered in OP_REQ; no Bus_Ready at all.
  task automatic test_timeout();
    int reqs = 0;
    int errs = 0;
    int valids = 0;
    bus_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; reqs += int'(bus_req); errs += int'(bus_err); valids += int'(operand_valid);
      step();
    end
    #1;
    checks++; if (reqs !== 4 || errs !== 0) begin
      errors++; $display("FAIL timeout_wait_phase: got req=%0d err=%0d want 4 0", reqs, errs);
    end
    checks++; if (bus_err !== 1'b1 || bus_req !== 1'b0) begin
      errors++; $display("FAIL timeout_abort_cycle: got err=%b req=%b want 1 0", bus_err, bus_req);
    end
    valids += int'(operand_valid);
    step();
    #1;
    valids += int'(operand_valid);
    checks++; if (cm1 !== 1'b1 || bus_err !== 1'b0) begin
      errors++; $display("FAIL timeout_next_m1: got cm1=%b err=%b want 1 0", cm1, bus_err);
    end
    checks++; if (itable !== 8'h00 || not_itable !== 8'hFF) begin
      errors++; $display("FAIL timeout_itable: got %h/%h want 00/ff", itable, not_itable);
    end
    checks++; if (operand !== 8'h5A || valids !== 0) begin
      errors++; $display("FAIL timeout_operand: got operand=%h valids=%0d want 5a 0", operand, valids);
    end
    $display("op fetch timeout bus_err seen, itable=%h", itable);
  endtask

  task automatic test_exec_hold();
    int ens = 0;
    bus_ready = 1'b1; bus_data = 8'h77; #1;
    step();
    bus_ready = 1'b0; #1;
    step();
    for (int i = 0; i < 5; i++) begin
      pa_ophd = (i == 2);
      p2_set_cm1 = (i == 4);
      p2_reset_itable = (i == 4);
      #1;
      ens += int'(dec_enable);
      if (i == 4) begin
        checks++; if (itable !== 8'h77 || cm1 !== 1'b0) begin
          errors++; $display("FAIL exec_hold_state: got itable=%h cm1=%b want 77 0", itable, cm1);
        end
      end
      step();
    end
    pa_ophd = 1'b0; p2_set_cm1 = 1'b0; p2_reset_itable = 1'b0; #1;
    checks++; if (ens !== 5) begin errors++; $display("FAIL exec_dec_enable: got %0d want 5", ens); end
    checks++; if (cm1 !== 1'b1 || itable !== 8'h00 || not_itable !== 8'hFF) begin
      errors++; $display("FAIL exec_reset_itable: got cm1=%b itable=%h not=%h want 1 00 ff", cm1, itable, not_itable);
    end
    $display("exec hold opcode=77 dec_enable_cycles=%0d", ens);
  endtask

  task automatic test_reset_mid_transfer();
    bus_ready = 1'b1; bus_data = 8'h3E; #1;
    step();
    bus_ready = 1'b0; pa_ophd = 1'b1; #1;
    step();
    pa_ophd = 1'b0; reset = 1'b1; bus_ready = 1'b1; bus_data = 8'hC3; #1;
    checks++; if (pc_inc !== 1'b0 || bus_req !== 1'b0) begin
      errors++; $display("FAIL rst_mid_strobes: got pc_inc=%b req=%b want 0 0", pc_inc, bus_req);
    end
    step();
    reset = 1'b0; bus_ready = 1'b0; #1;
    checks++; if (cm1 !== 1'b1 || bus_req !== 1'b1) begin
      errors++; $display("FAIL rst_mid_m1: got cm1=%b req=%b want 1 1", cm1, bus_req);
    end
    checks++; if (operand !== 8'h00 || itable !== 8'h00) begin
      errors++; $display("FAIL rst_mid_regs: got operand=%h itable=%h want 00 00", operand, itable);
    end
    $display("reset during op fetch, operand=%h", operand);
  endtask

  initial begin
    test_reset();
    test_ld_r_n();
    test_single_cycle();
    test_wait_states();
    test_timeout();
    test_exec_hold();
    test_reset_mid_transfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
